// File: rtl/dpr_pkg.sv
// Shared types and default timing for the partial-reconfiguration sequencer.
// The state encoding is visible to the top and to anything that decodes busy.
package dpr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECOUPLE,
      ST_STREAM,
      ST_WAIT_DONE,
      ST_RECOUPLE,
      ST_FAIL
   } dpr_state_t;

   localparam int DEF_WORD_W          = 32;
   localparam int DEF_BITSTREAM_WORDS = 1024;
   localparam int DEF_CNT_W           = 11;
   localparam int DEF_DECOUPLE_CYCLES = 16;
   localparam int DEF_TIMEOUT_CYCLES  = 10_000_000;
   localparam int DEF_MAX_RETRIES     = 3;

   // A repair is in flight in every state except the two resting ones.
   function automatic logic isActive(input dpr_state_t s);
      return (s != ST_IDLE) && (s != ST_FAIL);
   endfunction

endpackage

// File: rtl/dpr_skid_reg.sv
// One-entry valid/ready register between the bitstream source and the config port.
// Accepts a new word in the same cycle the held word drains, so throughput stays at one word per cycle.
module dpr_skid_reg #(
   parameter int WORD_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rstN,
   input  logic              i_flush,
   input  logic              i_inValid,
   input  logic [WORD_W-1:0] i_inData,
   output logic              o_inReady,
   output logic              o_outValid,
   output logic [WORD_W-1:0] o_outData,
   input  logic              i_outReady
);

   logic              r_valid;
   logic [WORD_W-1:0] r_data;

   assign o_inReady  = ~r_valid | i_outReady;
   assign o_outValid = r_valid;
   assign o_outData  = r_data;

   // Flush beats a load so a retry never carries a stale word into the next attempt.
   always_ff @(posedge i_clk) begin
      if (!i_rstN) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_inValid && o_inReady) begin
         r_valid <= 1'b1;
         r_data  <= i_inData;
      end else if (i_outReady) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dpr_sequencer.sv
// Repair sequencer: isolates the partition, streams a partial bitstream into the
// configuration port, retries on error/timeout and recouples once the oracle allows it.
module dpr_sequencer
   import dpr_pkg::*;
#(
   parameter int WORD_W          = DEF_WORD_W,
   parameter int BITSTREAM_WORDS = DEF_BITSTREAM_WORDS,
   parameter int CNT_W           = DEF_CNT_W,
   parameter int DECOUPLE_CYCLES = DEF_DECOUPLE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
   input  logic              clk_500mhz,
   input  logic              rst_n,
   input  logic              dpr_start,
   input  logic              veto,
   input  logic              bs_valid,
   input  logic [WORD_W-1:0] bs_data,
   output logic              bs_ready,
   output logic              bs_rewind,
   output logic              cfg_valid,
   output logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_ready,
   input  logic              cfg_done,
   input  logic              cfg_err,
   output logic              decouple,
   output logic              busy,
   output logic              dpr_done,
   output logic              dpr_fail,
   output logic [1:0]        retry_cnt
);

   localparam int SET_W = $clog2(DECOUPLE_CYCLES) + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(BITSTREAM_WORDS);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(DECOUPLE_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

   dpr_state_t       r_state,    w_stateNext;
   logic [SET_W-1:0] r_settle,   w_settleNext;
   logic [CNT_W-1:0] r_loadCnt,  w_loadCntNext;
   logic [CNT_W-1:0] r_wordCnt,  w_wordCntNext;
   logic [WD_W-1:0]  r_wdog,     w_wdogNext;
   logic [1:0]       r_retry,    w_retryNext;
   logic             r_fail,     w_failNext;
   logic             r_decouple, w_decoupleNext;
   logic             r_rewind,   w_rewindNext;
   logic             r_done,     w_doneNext;
   logic             r_released, w_releasedNext;
   logic             r_startQ;

   logic              w_trigger;
   logic              w_inStream;
   logic              w_skidInReady;
   logic              w_skidValid;
   logic [WORD_W-1:0] w_skidData;
   logic              w_bsReady;
   logic              w_load;
   logic              w_cfgValid;
   logic              w_cfgFire;
   logic              w_timeout;
   logic              w_flush;
   logic              w_retryPath;

   assign w_trigger  = dpr_start & ~r_startQ;
   assign w_inStream = (r_state == ST_STREAM);
   assign w_bsReady  = w_inStream & w_skidInReady & (r_loadCnt != LAST_WORD);
   assign w_load     = bs_valid & w_bsReady;
   assign w_cfgValid = w_inStream & w_skidValid;
   assign w_cfgFire  = w_cfgValid & cfg_ready;
   assign w_timeout  = (r_wdog == WD_LAST);

   dpr_skid_reg #(
      .WORD_W (WORD_W)
   ) u_skid (
      .i_clk      (clk_500mhz),
      .i_rstN     (rst_n),
      .i_flush    (w_flush),
      .i_inValid  (w_load),
      .i_inData   (bs_data),
      .o_inReady  (w_skidInReady),
      .o_outValid (w_skidValid),
      .o_outData  (w_skidData),
      .i_outReady (cfg_ready & w_inStream)
   );

   always_comb begin
      w_stateNext    = r_state;
      w_settleNext   = r_settle;
      w_loadCntNext  = r_loadCnt;
      w_wordCntNext  = r_wordCnt;
      w_wdogNext     = r_wdog;
      w_retryNext    = r_retry;
      w_failNext     = r_fail;
      w_decoupleNext = r_decouple;
      w_releasedNext = r_released;
      w_rewindNext   = 1'b0;
      w_doneNext     = 1'b0;
      w_flush        = 1'b0;
      w_retryPath    = 1'b0;

      case (r_state)
         ST_IDLE, ST_FAIL: begin
            if (w_trigger) begin
               w_failNext     = 1'b0;
               w_retryNext    = 2'd0;
               w_rewindNext   = 1'b1;
               w_decoupleNext = 1'b1;
               w_settleNext   = '0;
               w_stateNext    = ST_DECOUPLE;
            end
         end
         ST_DECOUPLE: begin
            if (r_settle == SETTLE_LAST) begin
               w_loadCntNext = '0;
               w_wordCntNext = '0;
               w_wdogNext    = '0;
               w_stateNext   = ST_STREAM;
            end else begin
               w_settleNext = r_settle + 1'b1;
            end
         end
         ST_STREAM: begin
            w_wdogNext = r_wdog + 1'b1;
            if (w_load) w_loadCntNext = r_loadCnt + 1'b1;
            if (w_cfgFire) w_wordCntNext = r_wordCnt + 1'b1;
            if (w_timeout) begin
               w_retryPath = 1'b1;
            end else if ((r_wordCnt == LAST_WORD) && !w_skidValid) begin
               w_stateNext = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            w_wdogNext = r_wdog + 1'b1;
            if (cfg_err || w_timeout) begin
               w_retryPath = 1'b1;
            end else if (cfg_done) begin
               w_releasedNext = 1'b0;
               w_stateNext    = ST_RECOUPLE;
            end
         end
         ST_RECOUPLE: begin
            // The partition stays isolated until the oracle lifts its veto.
            if (!r_released) begin
               if (!veto) begin
                  w_decoupleNext = 1'b0;
                  w_releasedNext = 1'b1;
                  w_settleNext   = '0;
               end
            end else if (r_settle == SETTLE_LAST) begin
               w_doneNext  = 1'b1;
               w_stateNext = ST_IDLE;
            end else begin
               w_settleNext = r_settle + 1'b1;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase

      if (w_retryPath) begin
         w_flush = 1'b1;
         if (r_retry < RETRY_MAX) begin
            w_retryNext  = r_retry + 1'b1;
            w_rewindNext = 1'b1;
            w_settleNext = '0;
            w_stateNext  = ST_DECOUPLE;
         end else begin
            w_failNext  = 1'b1;
            w_stateNext = ST_FAIL;
         end
      end
   end

   always_ff @(posedge clk_500mhz) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_settle   <= '0;
         r_loadCnt  <= '0;
         r_wordCnt  <= '0;
         r_wdog     <= '0;
         r_retry    <= 2'd0;
         r_fail     <= 1'b0;
         r_decouple <= 1'b0;
         r_rewind   <= 1'b0;
         r_done     <= 1'b0;
         r_released <= 1'b0;
         r_startQ   <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_settle   <= w_settleNext;
         r_loadCnt  <= w_loadCntNext;
         r_wordCnt  <= w_wordCntNext;
         r_wdog     <= w_wdogNext;
         r_retry    <= w_retryNext;
         r_fail     <= w_failNext;
         r_decouple <= w_decoupleNext;
         r_rewind   <= w_rewindNext;
         r_done     <= w_doneNext;
         r_released <= w_releasedNext;
         r_startQ   <= dpr_start;
      end
   end

   assign bs_ready  = w_bsReady;
   assign bs_rewind = r_rewind;
   assign cfg_valid = w_cfgValid;
   assign cfg_data  = w_skidData;
   assign decouple  = r_decouple;
   assign busy      = isActive(r_state);
   assign dpr_done  = r_done;
   assign dpr_fail  = r_fail;
   assign retry_cnt = r_retry;

endmodule

// File: tb/tb_dpr_sequencer.sv
// Scoreboard bench for dpr_sequencer: a bitstream source model, a config-port responder
// and per-repair checks on pulses, retries, timeouts, veto hold and reset.
module tb_dpr_sequencer;

   localparam int WORD_W   = 32;
   localparam int WORDS    = 4;
   localparam int SETTLE   = 2;
   localparam int TIMEOUT  = 50;
   localparam int RETRIES  = 3;
   localparam int RESP_DLY = 3;

   logic              clk_500mhz = 1'b0;
   logic              rst_n;
   logic              dpr_start;
   logic              veto;
   logic              bs_valid;
   logic [WORD_W-1:0] bs_data;
   logic              bs_ready;
   logic              bs_rewind;
   logic              cfg_valid;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              cfg_done;
   logic              cfg_err;
   logic              decouple;
   logic              busy;
   logic              dpr_done;
   logic              dpr_fail;
   logic [1:0]        retry_cnt;

   dpr_sequencer #(
      .WORD_W          (WORD_W),
      .BITSTREAM_WORDS (WORDS),
      .CNT_W           (3),
      .DECOUPLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES  (TIMEOUT),
      .MAX_RETRIES     (RETRIES)
   ) dut (
      .clk_500mhz (clk_500mhz),
      .rst_n      (rst_n),
      .dpr_start  (dpr_start),
      .veto       (veto),
      .bs_valid   (bs_valid),
      .bs_data    (bs_data),
      .bs_ready   (bs_ready),
      .bs_rewind  (bs_rewind),
      .cfg_valid  (cfg_valid),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .decouple   (decouple),
      .busy       (busy),
      .dpr_done   (dpr_done),
      .dpr_fail   (dpr_fail),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk_500mhz = ~clk_500mhz;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [WORD_W-1:0] expQ[$];
   int                respQ[$];
   int                rewindCycles[$];

   int   cycle = 0;
   int   srcIdx = 0;
   int   nRewind, nFire, nDone, extraFires, overRead, decLowBusy;
   int   loadsThisAttempt, fireThisAttempt;
   int   firstFireCycle, lastFireCycle, decFallCycle, doneCycle, failCycle;
   int   respCountdown, curResp;
   logic [WORD_W-1:0] firstFireData;
   logic [WORD_W-1:0] stallData;
   logic stallPending = 1'b0;
   logic prevDecouple = 1'b0;
   logic prevFail = 1'b0;
   logic lastBusy = 1'b0;
   logic readyMode;
   logic [3:0] readyPat = 4'b1001;
   int   readyPhase;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [WORD_W-1:0] srcWord(input int idx);
      if (idx < WORDS) return 32'hA5A0_0000 + 32'(idx) * 32'h0000_0101;
      return 32'hDEAD_0000 + 32'(idx);
   endfunction

   task automatic resetStats();
      nRewind = 0; nFire = 0; nDone = 0; extraFires = 0; overRead = 0; decLowBusy = 0;
      loadsThisAttempt = 0; fireThisAttempt = 0;
      firstFireCycle = 0; lastFireCycle = 0; decFallCycle = 0; doneCycle = 0; failCycle = 0;
      respCountdown = 0; curResp = 0; readyMode = 1'b0; readyPhase = 0;
      firstFireData = '0;
      rewindCycles.delete();
      respQ.delete();
   endtask

   // Observe at the falling edge, then drive the next inputs 1 time unit after the rising edge.
   task automatic stepCycle();
      logic adv, rew;
      @(negedge clk_500mhz);
      cycle++;
      adv = bs_valid && bs_ready;
      rew = bs_rewind;
      if (rst_n) begin
         if (stallPending) begin
            checkOutput("stall_valid", cfg_valid, 1);
            checkOutput("stall_data", cfg_data, stallData);
         end
         stallPending = cfg_valid && !cfg_ready;
         stallData    = cfg_data;
      end else begin
         stallPending = 1'b0;
      end
      if (bs_ready && loadsThisAttempt >= WORDS) overRead++;
      if (adv) loadsThisAttempt++;
      if (rew) begin
         nRewind++;
         rewindCycles.push_back(cycle);
         loadsThisAttempt = 0;
         fireThisAttempt  = 0;
         expQ.delete();
         for (int i = 0; i < WORDS; i++) expQ.push_back(srcWord(i));
      end
      if (cfg_valid && cfg_ready) begin
         nFire++;
         fireThisAttempt++;
         if (nFire == 1) firstFireData = cfg_data;
         if (fireThisAttempt == 1) firstFireCycle = cycle;
         if (fireThisAttempt == WORDS) begin
            lastFireCycle = cycle;
            respCountdown = RESP_DLY;
            curResp = (respQ.size() > 0) ? respQ.pop_front() : 0;
         end
         if (expQ.size() == 0) extraFires++;
         else checkOutput("cfg_data", cfg_data, expQ.pop_front());
      end
      if (prevDecouple && !decouple) decFallCycle = cycle;
      prevDecouple = decouple;
      if (dpr_fail && !prevFail) failCycle = cycle;
      prevFail = dpr_fail;
      if (dpr_done) begin
         nDone++;
         doneCycle = cycle;
      end
      if (busy && !decouple) decLowBusy++;
      lastBusy = busy;

      @(posedge clk_500mhz);
      #1;
      if (rew) srcIdx = 0;
      else if (adv) srcIdx++;
      bs_data = srcWord(srcIdx);
      if (readyMode) begin
         cfg_ready  = readyPat[readyPhase];
         readyPhase = (readyPhase + 1) % 4;
      end else begin
         cfg_ready = 1'b1;
      end
      cfg_done = 1'b0;
      cfg_err  = 1'b0;
      if (respCountdown > 0) begin
         respCountdown--;
         if (respCountdown == 0) begin
            cfg_done = (curResp == 1);
            cfg_err  = (curResp == 2);
         end
      end
   endtask

   // Raise dpr_start for one sampled edge; optionally keep it high afterwards.
   task automatic applyStimulus(input logic holdStart);
      dpr_start = 1'b1;
      stepCycle();
      if (!holdStart) dpr_start = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      int n = 0;
      do begin
         stepCycle();
         n++;
      end while (lastBusy && n < maxCycles);
      checkOutput(tag, lastBusy, 0);
   endtask

   function automatic logic [63:0] outVector();
      return {23'd0, bs_ready, bs_rewind, cfg_valid, cfg_data, decouple, busy, dpr_done, dpr_fail, retry_cnt};
   endfunction

   initial begin
      rst_n = 1'b0; dpr_start = 1'b0; veto = 1'b0; bs_valid = 1'b0; bs_data = '0;
      cfg_ready = 1'b1; cfg_done = 1'b0; cfg_err = 1'b0;
      resetStats();
      repeat (3) @(posedge clk_500mhz);
      @(negedge clk_500mhz);
      checkOutput("reset_outputs", outVector(), 0);
      @(posedge clk_500mhz);
      #1;
      rst_n = 1'b1; bs_valid = 1'b1; bs_data = srcWord(0);

      $display("[TB] nominal repair");
      resetStats();
      respQ.push_back(1);
      applyStimulus(1'b0);
      waitIdle("nom_idle", 200);
      checkOutput("nom_rewinds", nRewind, 1);
      checkOutput("nom_fires", nFire, WORDS);
      checkOutput("nom_consecutive", lastFireCycle - firstFireCycle, WORDS - 1);
      checkOutput("nom_done", nDone, 1);
      checkOutput("nom_dec_low", decLowBusy, SETTLE);
      checkOutput("nom_done_lag", doneCycle - decFallCycle, SETTLE);
      checkOutput("nom_retry", retry_cnt, 0);
      checkOutput("nom_extra", extraFires, 0);
      checkOutput("nom_leftover", expQ.size(), 0);

      $display("[TB] backpressure");
      resetStats();
      readyMode = 1'b1;
      respQ.push_back(1);
      applyStimulus(1'b0);
      waitIdle("bp_idle", 200);
      checkOutput("bp_fires", nFire, WORDS);
      checkOutput("bp_overread", overRead, 0);
      checkOutput("bp_extra", extraFires, 0);
      checkOutput("bp_leftover", expQ.size(), 0);
      checkOutput("bp_done", nDone, 1);

      $display("[TB] retry after error");
      resetStats();
      respQ.push_back(2);
      respQ.push_back(1);
      applyStimulus(1'b0);
      waitIdle("rt_idle", 300);
      checkOutput("rt_rewinds", nRewind, 2);
      checkOutput("rt_fires", nFire, 2 * WORDS);
      checkOutput("rt_retry", retry_cnt, 1);
      checkOutput("rt_done", nDone, 1);
      checkOutput("rt_fail", dpr_fail, 0);

      $display("[TB] retry exhaustion");
      resetStats();
      applyStimulus(1'b0);
      waitIdle("ex_idle", 400);
      checkOutput("ex_rewinds", nRewind, RETRIES + 1);
      checkOutput("ex_fires", nFire, (RETRIES + 1) * WORDS);
      for (int i = 1; i < rewindCycles.size(); i++)
         checkOutput("ex_attempt_len", rewindCycles[i] - rewindCycles[i-1], SETTLE + TIMEOUT);
      if (rewindCycles.size() > 0)
         checkOutput("ex_last_attempt", failCycle - rewindCycles[rewindCycles.size()-1], SETTLE + TIMEOUT);
      checkOutput("ex_fail", dpr_fail, 1);
      checkOutput("ex_decouple", decouple, 1);
      checkOutput("ex_busy", busy, 0);
      checkOutput("ex_retry", retry_cnt, RETRIES);
      checkOutput("ex_done", nDone, 0);

      $display("[TB] recovery from failure");
      resetStats();
      respQ.push_back(1);
      applyStimulus(1'b0);
      checkOutput("rc_fail_clr", dpr_fail, 0);
      checkOutput("rc_busy", busy, 1);
      checkOutput("rc_retry_clr", retry_cnt, 0);
      waitIdle("rc_idle", 200);
      checkOutput("rc_done", nDone, 1);

      $display("[TB] veto hold with level start");
      resetStats();
      veto = 1'b1;
      respQ.push_back(1);
      applyStimulus(1'b1);
      repeat (40) stepCycle();
      checkOutput("vt_held_dec", decouple, 1);
      checkOutput("vt_held_busy", busy, 1);
      checkOutput("vt_held_done", nDone, 0);
      veto = 1'b0;
      waitIdle("vt_idle", 100);
      checkOutput("vt_done", nDone, 1);
      checkOutput("vt_done_lag", doneCycle - decFallCycle, SETTLE);
      repeat (20) stepCycle();
      checkOutput("vt_no_retrigger", nRewind, 1);
      checkOutput("vt_rest_busy", busy, 0);
      dpr_start = 1'b0;
      stepCycle();

      $display("[TB] reset mid-stream");
      resetStats();
      respQ.push_back(1);
      applyStimulus(1'b0);
      for (int n = 0; n < 40 && nFire < 2; n++) stepCycle();
      checkOutput("rs_prefill", nFire, 2);
      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      checkOutput("rs_outputs", outVector(), 0);
      repeat (5) stepCycle();
      checkOutput("rs_no_rewind", nRewind, 1);
      resetStats();
      respQ.push_back(1);
      applyStimulus(1'b0);
      waitIdle("rs_idle", 200);
      checkOutput("rs_first_word", firstFireData, srcWord(0));
      checkOutput("rs_fires", nFire, WORDS);
      checkOutput("rs_done", nDone, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
